alu_seq: RTL

- Parametrised, registered successor to the combinational 32-bit datapath ALU.
- Keeps the existing opcode map.
- Adds a START/BUSY/DONE handshake, a WIDTH-cycle iterative signed multiplier with full HI:LO product, and overflow-correct signed set-less-than.
- Sits between the register file read ports and the writeback mux in the multi-cycle processor; the control unit starts one operation at a time and waits for DONE.

---
 rtl/alu_seq_if.sv | 23 ++
 rtl/alu_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between the control unit and alu_seq.
//   start           one-cycle operation request
//   op1, op2, oprn  operands and opcode, captured with start
//   out, hi, zero   registered result (hi = upper product half / remainder)
//   busy, done      iterative-op-in-progress flag and one-cycle completion pulse
// master = control unit side, slave = alu_seq side.
interface alu_seq_if #(
  parameter int WIDTH      = 32,
  parameter int OPRN_WIDTH = 6
);
  logic                  start;
  logic [WIDTH-1:0]      op1;
  logic [WIDTH-1:0]      op2;
  logic [OPRN_WIDTH-1:0] oprn;
  logic [WIDTH-1:0]      out;
  logic [WIDTH-1:0]      hi;
  logic                  zero;
  logic                  busy;
  logic                  done;

  modport master (output start, op1, op2, oprn, input out, hi, zero, busy, done);
  modport slave  (input start, op1, op2, oprn, output out, hi, zero, busy, done);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/busy/done handshake.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_seq_if.slave: start/op1/op2/oprn in, out/hi/zero/busy/done out
// Single-cycle ops (add, sub, shr, shl, and, or, nor, slt, illegal) finish at
// the sampling edge. Signed mul runs WIDTH shift-add steps then a sign fix-up.
// Optional macro ALU_SEQ_DIV_EN: opcode 0xA becomes an unsigned restoring
// divide on the same iterative path (out = quotient, hi = remainder).
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// ITER  | one shift-add (or shift-subtract) step per cycle
// FIN   | sign correction, results registered, done pulsed
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int OPRN_WIDTH = 6
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             neg;

  logic [3:0]         op;
  logic               iter_op;
  logic               accept;
  logic [WIDTH-1:0]   res1;
  logic [WIDTH-1:0]   cap_a;
  logic [WIDTH-1:0]   cap_b;
  logic [WIDTH:0]     step_sum;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fin_out;
  logic [WIDTH-1:0]   fin_hi;

  // Only oprn[3:0] is decoded; the upper bits are deliberately ignored.
  logic unused_oprn;
  assign unused_oprn = ^bus.oprn;

`ifdef ALU_SEQ_DIV_EN
  logic           is_div;
  logic [WIDTH:0] trial;
`endif

  // Decode and single-cycle result, plus operand capture values
  always_comb begin
    op      = bus.oprn[3:0];
    iter_op = (op == 4'h3);
`ifdef ALU_SEQ_DIV_EN
    if (op == 4'hA) iter_op = 1'b1;
`endif
    res1 = '0;
    case (op)
      4'h1: res1 = bus.op1 + bus.op2;
      4'h2: res1 = bus.op1 - bus.op2;
      4'h4: res1 = (bus.op2 >= WIDTH_V) ? '0 : (bus.op1 >> bus.op2);
      4'h5: res1 = (bus.op2 >= WIDTH_V) ? '0 : (bus.op1 << bus.op2);
      4'h6: res1 = bus.op1 & bus.op2;
      4'h7: res1 = bus.op1 | bus.op2;
      4'h8: res1 = ~(bus.op1 | bus.op2);
      4'h9: res1 = {{(WIDTH-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
      default: res1 = '0;
    endcase
    // mul works on magnitudes; the most negative value's magnitude still
    // fits as an unsigned WIDTH-bit number.
    cap_a = bus.op1[WIDTH-1] ? -bus.op1 : bus.op1;
    cap_b = bus.op2[WIDTH-1] ? -bus.op2 : bus.op2;
`ifdef ALU_SEQ_DIV_EN
    if (op == 4'hA) begin
      cap_a = bus.op2;  // divisor
      cap_b = bus.op1;  // dividend, shifted out of acc_lo as quotient fills in
    end
`endif
  end

  // One iteration step; acc_lo holds the multiplier (or dividend) bits
  always_comb begin
    step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    step_hi  = step_sum[WIDTH:1];
    step_lo  = {step_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, mcand};
    if (is_div) begin
      // A zero divisor always succeeds here, which naturally yields an
      // all-ones quotient and the dividend as remainder.
      if (!trial[WIDTH]) begin
        step_hi = trial[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
    prod_fix = neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    fin_out  = prod_fix[WIDTH-1:0];
    fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (iter_op) state_nxt = ITER;
        end
      end
      ITER:    if (cnt == CW'(WIDTH-1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out  <= '0;
      bus.hi   <= '0;
      bus.zero <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      cnt      <= '0;
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      neg      <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      is_div   <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (iter_op) begin
              bus.busy <= 1'b1;
              cnt      <= '0;
              mcand    <= cap_a;
              acc_hi   <= '0;
              acc_lo   <= cap_b;
              neg      <= (op == 4'h3) && (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
`ifdef ALU_SEQ_DIV_EN
              is_div   <= (op == 4'hA);
`endif
            end else begin
              bus.out  <= res1;
              bus.hi   <= '0;
              bus.zero <= (res1 == '0);
              bus.done <= 1'b1;
            end
          end
        end
        ITER: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
        end
        FIN: begin
          bus.out  <= fin_out;
          bus.hi   <= fin_hi;
          bus.zero <= (fin_out == '0);
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
